fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage RV32I pipeline. It owns the program counter and issues in-order requests to the instruction memory, which may accept requests late and answer with variable latency. It buffers returned instructions and drives the IF/ID pipeline register that feeds the decode stage (InstrD, PCD, PCPlus4D). It also handles decode stalls, decode flushes and branch/jump redirects from execute, discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Response buffer of {pc, instr} entries plus the PC tag queue for in-flight requests.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  fetch_entry_t    wdata,
    output fetch_entry_t    rdata,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty,
    input  logic            tag_push,
    input  logic [XLEN-1:0] tag_wdata,
    input  logic            tag_pop,
    output logic [XLEN-1:0] tag_rdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t    mem     [DEPTH];
    logic [XLEN-1:0] tag_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   tag_wr_ptr;
    logic [AW-1:0]   tag_rd_ptr;

    assign rdata     = mem[rd_ptr];
    assign tag_rdata = tag_mem[tag_rd_ptr];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);

    // Response FIFO pointers and occupancy; clear drops all buffered entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Tag queue pointers; stale requests still return, so clear does not touch these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
        end else begin
            if (tag_push) tag_wr_ptr <= tag_wr_ptr + AW'(1);
            if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + AW'(1);
        end
    end

    // Storage arrays, no reset needed.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
        if (tag_push)       tag_mem[tag_wr_ptr] <= tag_wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, credit-gated imem requests, response buffering and IF/ID register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic [SW-1:0]   credit_used;
    logic            fire;
    logic            rsp_live;
    logic            rsp_drop;
    logic            bypass;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    fifo_wdata;
    fetch_entry_t    fifo_rdata;
    logic [XLEN-1:0] rsp_tag;

    // Request side: outstanding plus buffered responses never exceed DEPTH.
    assign credit_used    = {1'b0, inflight} + {1'b0, fifo_count};
    assign imem_req_valid = !PCSrcE && (credit_used < SW'(DEPTH));
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid && imem_req_ready;
    assign inflight_next  = inflight + CW'(fire) - CW'(imem_rsp_valid);

    // Response side: stale responses are dropped, live ones bypass or get buffered.
    assign rsp_live   = imem_rsp_valid && (discard == '0);
    assign rsp_drop   = imem_rsp_valid && (discard != '0);
    assign bypass     = fifo_empty && rsp_live && !StallD && !FlushD && !PCSrcE;
    assign fifo_push  = rsp_live && !PCSrcE && !bypass;
    assign fifo_pop   = !fifo_empty && !PCSrcE && !FlushD && !StallD;
    assign fifo_wdata = '{pc: rsp_tag, instr: imem_rsp_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (PCSrcE),
        .wdata     (fifo_wdata),
        .rdata     (fifo_rdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .tag_push  (fire),
        .tag_wdata (pc),
        .tag_pop   (imem_rsp_valid),
        .tag_rdata (rsp_tag)
    );

    // PC, in-flight and discard counters; a redirect marks every outstanding response stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            if (PCSrcE) begin
                pc      <= PCTargetE;
                discard <= inflight_next;
            end else begin
                if (fire)     pc      <= pc + XLEN'(4);
                if (rsp_drop) discard <= discard - CW'(1);
            end
        end
    end

    // IF/ID register: squash, hold, drain buffer, bypass, else bubble (PCD holds on bubble).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (PCSrcE || FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (StallD) begin
            ValidD <= ValidD;
        end else if (!fifo_empty) begin
            InstrD   <= fifo_rdata.instr;
            PCD      <= fifo_rdata.pc;
            PCPlus4D <= fifo_rdata.pc + XLEN'(4);
            ValidD   <= 1'b1;
        end else if (rsp_live) begin
            InstrD   <= imem_rsp_data;
            PCD      <= rsp_tag;
            PCPlus4D <= rsp_tag + XLEN'(4);
            ValidD   <= 1'b1;
        end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end

    // Memory protocol sanity: no orphan responses, no push into a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n) !(imem_rsp_valid && (inflight == '0)));
    assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order variable-latency instruction memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          lat    = 1;
    int          cycle  = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] hold_addr;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    // One clock: sample the handshake before the edge, then advance the memory model.
    task automatic step();
        logic        f;
        logic        r;
        logic [31:0] a;
        #1;
        f = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        r = imem_rsp_valid;
        @(posedge clk);
        #1;
        cycle++;
        if (r && mq.size() != 0) void'(mq.pop_front());
        if (f) mq.push_back('{addr: a, due: cycle - 1 + lat});
        if (mq.size() != 0 && mq[0].due <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic check_instr();
        check("pcd", PCD, exp_pc);
        check("instr", InstrD, mem_word(exp_pc));
        check("pcp4", PCPlus4D, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
    endtask

    // Advance to the next valid IF/ID entry, tolerating up to max_wait bubbles.
    task automatic next_valid(input int max_wait);
        int n;
        n = 0;
        step();
        while (!ValidD && n < max_wait) begin
            step();
            n++;
        end
        check("valid", 32'(ValidD), 32'd1);
        if (ValidD) check_instr();
    endtask

    task automatic do_reset(input int l);
        rst_n          = 1'b0;
        lat            = l;
        mq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_req_ready = 1'b1;
        StallD         = 1'b0;
        FlushD         = 1'b0;
        PCSrcE         = 1'b0;
        PCTargetE      = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_reqv", 32'(imem_req_valid), 32'd1);
        check("rst_addr", imem_req_addr, 32'h0);
        check("rst_instr", InstrD, NOP_INSTR);
        check("rst_validd", 32'(ValidD), 32'd0);
        check("rst_pcd", PCD, 32'h0);
        check("rst_pcp4", PCPlus4D, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        // Zero-wait memory: one instruction per cycle, first valid two edges after reset.
        do_reset(1);
        step();
        check("first_bubble", InstrD, NOP_INSTR);
        check("second_addr", imem_req_addr, 32'h4);
        exp_pc = 32'h0;
        for (int i = 0; i < 6; i++) next_valid(0);

        // Decode stall: IF/ID frozen, requests stop at the credit limit, stream resumes intact.
        StallD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_pcd", PCD, exp_pc - 32'd4);
            check("stall_reqv", 32'(imem_req_valid), 32'd0);
        end
        StallD = 1'b0;
        for (int i = 0; i < 6; i++) next_valid(0);

        // Memory back-pressure: address held, pc does not advance.
        hold_addr      = exp_pc + 32'd4;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_addr", imem_req_addr, hold_addr);
            if (ValidD && i == 0) check_instr();
        end
        imem_req_ready = 1'b1;
        next_valid(4);
        for (int i = 0; i < 3; i++) next_valid(0);

        // Decode flush: one bubble, nothing lost.
        FlushD = 1'b1;
        step();
        FlushD = 1'b0;
        check("flush_validd", 32'(ValidD), 32'd0);
        check("flush_instr", InstrD, NOP_INSTR);
        for (int i = 0; i < 4; i++) next_valid(0);

        // Redirect together with stall, to the top of the address space to exercise wrap.
        PCSrcE    = 1'b1;
        StallD    = 1'b1;
        PCTargetE = 32'hFFFF_FFF8;
        step();
        PCSrcE = 1'b0;
        StallD = 1'b0;
        check("redir_validd", 32'(ValidD), 32'd0);
        check("redir_instr", InstrD, NOP_INSTR);
        check("redir_pcd_hold", PCD, exp_pc - 32'd4);
        exp_pc = 32'hFFFF_FFF8;
        next_valid(3);
        next_valid(0);
        check("wrap_pcp4", PCPlus4D, 32'h0000_0000);
        next_valid(0);
        next_valid(0);

        // Mid-operation reset, 3-cycle memory, redirect with two requests in flight.
        do_reset(3);
        step();
        step();
        check("lat3_credit", 32'(imem_req_valid), 32'd0);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0100;
        step();
        PCSrcE = 1'b0;
        check("lat3_validd", 32'(ValidD), 32'd0);
        check("lat3_instr", InstrD, NOP_INSTR);
        check("lat3_stale_credit", 32'(imem_req_valid), 32'd0);
        exp_pc = 32'h0000_0100;
        next_valid(12);
        next_valid(8);
        next_valid(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
